// File: rtl/sobel_window_gen.sv
// Raster-scan 3x3 window generator feeding the Sobel calculator from an 8-bit pixel stream.
// Latency: 1 cycle from accepting pixel (r,c) with r>=2, c>=2 to done_o carrying its window.
// Backpressure: none; every valid_i cycle is accepted, and idle cycles hold the window.
module sobel_window_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_i,
  input  logic       valid_i,
  input  logic       sof_i,
  output logic [7:0] d0_o,
  output logic [7:0] d1_o,
  output logic [7:0] d2_o,
  output logic [7:0] d3_o,
  output logic [7:0] d4_o,
  output logic [7:0] d5_o,
  output logic [7:0] d6_o,
  output logic [7:0] d7_o,
  output logic [7:0] d8_o,
  output logic       done_o,
  output logic       frame_end_o
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;

  // line1 holds the previous line, line2 the line before that
  logic [7:0] line1_q [IMG_W];
  logic [7:0] line2_q [IMG_W];
  logic [7:0] rd1, rd2;

  // win_q[0..8] = d0..d8, row-major, d8 is the newest pixel
  logic [7:0] win_q [9];
  logic [7:0] win_d [9];

  logic done_q, done_d;
  logic fe_q, fe_d;

  // Position of the pixel on the input this cycle; sof forces (0,0) regardless of counters
  always_comb begin
    cur_col = col_q;
    cur_row = row_q;
    if (sof_i) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  // Counter advance on accept: col wraps into row, last pixel of the frame wraps both
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_i) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  assign rd1 = line1_q[cur_col];
  assign rd2 = line2_q[cur_col];

  // Window shifts left one column per accepted pixel; new right column comes from the line stores
  always_comb begin
    for (int i = 0; i < 9; i++) win_d[i] = win_q[i];
    if (valid_i) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = rd2;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = rd1;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_i;
    end
  end

  // A window is complete only once two full lines are buffered and three columns are in;
  // the column gate also stops windows straddling a line wrap
  always_comb begin
    done_d = valid_i && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
    fe_d   = done_d && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
  end

  // Control and window registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      done_q <= 1'b0;
      fe_q   <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      done_q <= done_d;
      fe_q   <= fe_d;
      for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
    end
  end

  // Line stores are never cleared: the row gate masks stale contents after reset or resync
  always_ff @(posedge clk) begin
    if (valid_i) begin
      line2_q[cur_col] <= line1_q[cur_col];
      line1_q[cur_col] <= pix_i;
    end
  end

  assign d0_o        = win_q[0];
  assign d1_o        = win_q[1];
  assign d2_o        = win_q[2];
  assign d3_o        = win_q[3];
  assign d4_o        = win_q[4];
  assign d5_o        = win_q[5];
  assign d6_o        = win_q[6];
  assign d7_o        = win_q[7];
  assign d8_o        = win_q[8];
  assign done_o      = done_q;
  assign frame_end_o = fe_q;

endmodule
